des_key_sched: RTL and testbench
================================

Name: des_key_sched

Overview:
- Iterative DES key schedule. Accepts one 64-bit key and streams the 16 48-bit round keys, one per accepted handshake.
- Sits directly upstream of the round datapath and drives its 48-bit k input.
- Keeps C/D 28-bit halves in registers, applies the per-round rotation, and presents PC-2 output from a register.

Parameters:
- NR, 16, number of rounds emitted per key; fixed by DES, exposed only for the bench.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- key  input  64  DES key, bit 63 = DES bit 1; parity bits ignored by PC-1
- key_valid  input  1  key present
- key_ready  output  1  block can accept a key
- dec  input  1  sampled with key; 1 = emit keys in decrypt order (only with DES_KEY_SCHED_DEC_EN)
- rk  output  48  current round key, bit 47 = PC-2 bit 1
- rk_idx  output  4  round index of rk, 0..15 = K1..K16
- rk_valid  output  1  rk valid
- rk_ready  input  1  consumer accepts rk
- rk_last  output  1  rk is final key of the sequence

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, C=D=0, rk=0, rk_idx=0, rk_valid=0, rk_last=0, key_ready=1.
- States:
  - IDLE: key_ready=1, rk_valid=0.
  - RUN: key_ready=0, rk_valid=1.
- Load (IDLE, key_valid=1): take PC-1 of key into C0/D0. Apply the round-1 rotation (left by 1). Register PC-2 into rk with rk_idx=0. Enter RUN.
- Latency: rk_valid rises the cycle after the key handshake.
- Advance (RUN, rk_ready=1, rk_last=0):
  - Rotate C/D left by SHIFT[rk_idx+1], where SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Update rk and increment rk_idx in the same edge.
  - Result: back-to-back keys, one per cycle with no bubbles.
- Stall (RUN, rk_ready=0): rk, rk_idx, rk_valid, rk_last and C/D all hold.
- Finish (RUN, rk_ready=1, rk_last=1):
  - Next cycle: IDLE, rk_valid=0, key_ready=1.
  - A new key is accepted no earlier than that cycle. No same-cycle reload.
- rk_last = 1 exactly when the emitted key is the 16th of the sequence (rk_idx=15 in encrypt order).
- key_valid during RUN is ignored; the key is not captured.
- Cumulative rotation after K16 is 28, so C/D equal C0/D0 at the end.
- Async reset mid-sequence aborts immediately to reset values. No partial key survives.

Optional Feature:
- Macro: DES_KEY_SCHED_DEC_EN.
- Defined, dec=1 at load:
  - C/D load as C0/D0 with no rotation, so the first rk = K16 with rk_idx=15.
  - Each advance rotates right by SHIFT[rk_idx] and decrements rk_idx.
  - rk_last when rk_idx=0.
- Defined, dec=0: encrypt order as above.
- Not defined: dec is ignored; encrypt order only; no right-rotator logic is synthesised.

Decomposition:
- Package des_pkg: PC-1 (56 entries) and PC-2 (48 entries) permutation constants, the SHIFT table, C/D width constant 28, state enum {IDLE, RUN}.
- One sub-module, des_pc2: purely combinational 56 -> 48 selection, reusable by a future unrolled core.
- PC-1 and rotation stay inline.

Test Plan:
- Encrypt vector: key=133457799BBCDFF1, dec=0, rk_ready=1 -> rk=1B02EFFC7072 (idx 0) one cycle after handshake, 79AED9DBC9E5 (idx 1) next cycle, CB3D8B0E17F5 (idx 15) with rk_last=1 on the 16th cycle, key_ready=1 the cycle after.
- Backpressure: same key, rk_ready held 0 for 5 cycles at idx 3 -> rk/idx stable; sequence resumes unchanged and all 16 keys match the unstalled run.
- Ignored load: pulse key_valid with FFFFFFFFFFFFFFFF during RUN -> no effect on remaining keys; key_ready stays 0 until after rk_last handshake.
- Reset mid-run: deassert rst_n at idx 7 -> rk_valid=0, rk=0, key_ready=1 asynchronously; reload 133457799BBCDFF1 -> first rk 1B02EFFC7072.
- Decrypt (DES_KEY_SCHED_DEC_EN): key=133457799BBCDFF1, dec=1 -> first rk=CB3D8B0E17F5 idx 15; last rk=1B02EFFC7072 idx 0 with rk_last=1.
- Parity independence: key=133457799BBCDFF1 XOR 0101010101010101 -> identical 16-key stream.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 selections, per-round shift table, FSM states.
package des_pkg;

    localparam int unsigned CD_W = 28;

    // Table entries use DES numbering: entry value n selects DES bit n (1 = MSB).
    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 selection: 56-bit C||D (bit 55 = DES bit 1) to 48-bit round key.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0] cd,
    output logic [47:0]       k
);

    always_comb begin
        k = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            k[47-i] = cd[56-PC2[i]];
        end
    end

endmodule

// File: rtl/des_key_sched.sv
// Iterative DES key schedule streaming K1..K16 over a valid/ready handshake.
// Optional decrypt ordering (K16..K1) is compiled in with `define DES_KEY_SCHED_DEC_EN.
module des_key_sched
    import des_pkg::*;
#(
    parameter int unsigned NR = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        dec,
    output logic [47:0] rk,
    output logic [3:0]  rk_idx,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic        rk_last
);

    localparam logic [3:0] LAST_IDX = 4'(NR - 1);

    state_e            state_q, state_d;
    logic [CD_W-1:0]   c_q, c_d, d_q, d_d;
    logic [3:0]        idx_q, idx_d;
    logic [47:0]       rk_q, pc2_out;
    logic              load_rk;
    logic [55:0]       pc1_out;
    logic [3:0]        idx_inc;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1[i]];
        end
        return r;
    endfunction

    function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
    endfunction

`ifdef DES_KEY_SCHED_DEC_EN
    logic dec_q, dec_d;

    function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
    endfunction
`else
    logic unused_dec;
    assign unused_dec = dec;
`endif

    assign pc1_out = pc1(key);
    assign idx_inc = idx_q + 4'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (key_valid) state_d = RUN;
            RUN:  if (rk_ready && rk_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        key_ready = (state_q == IDLE);
        rk_valid  = (state_q == RUN);
`ifdef DES_KEY_SCHED_DEC_EN
        rk_last   = (state_q == RUN) && (idx_q == (dec_q ? 4'd0 : LAST_IDX));
`else
        rk_last   = (state_q == RUN) && (idx_q == LAST_IDX);
`endif
    end

    // C/D datapath; rk is registered from PC-2 of the next C/D so it lines up with idx.
    always_comb begin
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        load_rk = 1'b0;
`ifdef DES_KEY_SCHED_DEC_EN
        dec_d   = dec_q;
`endif
        if (state_q == IDLE && key_valid) begin
            load_rk = 1'b1;
`ifdef DES_KEY_SCHED_DEC_EN
            dec_d   = dec;
            if (dec) begin
                c_d   = pc1_out[55:28];
                d_d   = pc1_out[27:0];
                idx_d = LAST_IDX;
            end else begin
                c_d   = rotl(pc1_out[55:28], SHIFT[0]);
                d_d   = rotl(pc1_out[27:0], SHIFT[0]);
                idx_d = '0;
            end
`else
            c_d   = rotl(pc1_out[55:28], SHIFT[0]);
            d_d   = rotl(pc1_out[27:0], SHIFT[0]);
            idx_d = '0;
`endif
        end else if (state_q == RUN && rk_ready && !rk_last) begin
            load_rk = 1'b1;
`ifdef DES_KEY_SCHED_DEC_EN
            if (dec_q) begin
                c_d   = rotr(c_q, SHIFT[idx_q]);
                d_d   = rotr(d_q, SHIFT[idx_q]);
                idx_d = idx_q - 4'd1;
            end else begin
                c_d   = rotl(c_q, SHIFT[idx_inc]);
                d_d   = rotl(d_q, SHIFT[idx_inc]);
                idx_d = idx_inc;
            end
`else
            c_d   = rotl(c_q, SHIFT[idx_inc]);
            d_d   = rotl(d_q, SHIFT[idx_inc]);
            idx_d = idx_inc;
`endif
        end
    end

    des_pc2 u_pc2 (
        .cd (({c_d, d_d})),
        .k  (pc2_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q   <= '0;
            d_q   <= '0;
            idx_q <= '0;
            rk_q  <= '0;
`ifdef DES_KEY_SCHED_DEC_EN
            dec_q <= 1'b0;
`endif
        end else begin
            c_q   <= c_d;
            d_q   <= d_d;
            idx_q <= idx_d;
            if (load_rk) rk_q <= pc2_out;
`ifdef DES_KEY_SCHED_DEC_EN
            dec_q <= dec_d;
`endif
        end
    end

    assign rk     = rk_q;
    assign rk_idx = idx_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the classic 133457799BBCDFF1 key schedule.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] key;
    logic        key_valid;
    logic        key_ready;
    logic        dec;
    logic [47:0] rk;
    logic [3:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic        rk_last;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] KEY0   = 64'h133457799BBCDFF1;
    localparam logic [63:0] PARITY = 64'h0101010101010101;

    logic [47:0] kexp [16];

    typedef struct {
        string       tag;
        logic [63:0] key;
        logic        dec;
        int          stall_i;
        int          stall_n;
        int          junk_i;
        logic        rev;
    } vec_t;

    vec_t vecs [5];

    des_key_sched #(.NR(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .dec       (dec),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_last   (rk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Caller is positioned at a negedge with the DUT idle.
    task automatic run_seq(input vec_t v);
        int e_i;
        chk({v.tag, " key_ready idle"}, 64'(key_ready), 64'd1);
        key       = v.key;
        dec       = v.dec;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key       = '0;
        for (int i = 0; i < 16; i++) begin
            e_i = v.rev ? 15 - i : i;
            chk($sformatf("%s rk[%0d]", v.tag, i),   64'(rk),        64'(kexp[e_i]));
            chk($sformatf("%s idx[%0d]", v.tag, i),  64'(rk_idx),    64'(e_i));
            chk($sformatf("%s last[%0d]", v.tag, i), 64'(rk_last),   64'(i == 15));
            chk($sformatf("%s valid[%0d]", v.tag, i), 64'(rk_valid), 64'd1);
            chk($sformatf("%s kready[%0d]", v.tag, i), 64'(key_ready), 64'd0);
            if (i == v.junk_i) begin
                key_valid = 1'b1;
                key       = '1;
            end
            if (i == v.stall_i) begin
                rk_ready = 1'b0;
                for (int s = 0; s < v.stall_n; s++) begin
                    @(negedge clk);
                    key_valid = 1'b0;
                    chk($sformatf("%s stall rk[%0d]", v.tag, s),  64'(rk),       64'(kexp[e_i]));
                    chk($sformatf("%s stall idx[%0d]", v.tag, s), 64'(rk_idx),   64'(e_i));
                    chk($sformatf("%s stall last[%0d]", v.tag, s), 64'(rk_last), 64'(i == 15));
                    chk($sformatf("%s stall valid[%0d]", v.tag, s), 64'(rk_valid), 64'd1);
                end
                rk_ready = 1'b1;
            end
            @(negedge clk);
            key_valid = 1'b0;
            key       = '0;
        end
        chk({v.tag, " done valid"}, 64'(rk_valid),  64'd0);
        chk({v.tag, " done kready"}, 64'(key_ready), 64'd1);
        chk({v.tag, " done last"},  64'(rk_last),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic rev_dec;
`ifdef DES_KEY_SCHED_DEC_EN
        rev_dec = 1'b1;
`else
        rev_dec = 1'b0;
`endif
        kexp = '{
            48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
            48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
            48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
            48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
        };
        vecs[0] = '{"nominal",   KEY0,          1'b0, -1, 0, -1, 1'b0};
        vecs[1] = '{"backpress", KEY0,          1'b0,  3, 5, -1, 1'b0};
        vecs[2] = '{"ignload",   KEY0,          1'b0,  9, 2,  5, 1'b0};
        vecs[3] = '{"parity",    KEY0 ^ PARITY, 1'b0, 15, 3, -1, 1'b0};
        vecs[4] = '{"decsel",    KEY0,          1'b1,  0, 2, 15, rev_dec};

        rst_n     = 1'b0;
        key       = '0;
        key_valid = 1'b0;
        dec       = 1'b0;
        rk_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset valid",  64'(rk_valid),  64'd0);
        chk("reset kready", 64'(key_ready), 64'd1);
        chk("reset rk",     64'(rk),        64'd0);
        chk("reset idx",    64'(rk_idx),    64'd0);
        chk("reset last",   64'(rk_last),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v]);
        end

        // Asynchronous reset in the middle of a sequence.
        key       = KEY0;
        dec       = 1'b0;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("midrst idx7", 64'(rk_idx), 64'd7);
        chk("midrst rk7",  64'(rk),     64'(kexp[7]));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst valid",  64'(rk_valid),  64'd0);
        chk("midrst rk",     64'(rk),        64'd0);
        chk("midrst kready", 64'(key_ready), 64'd1);
        chk("midrst idx",    64'(rk_idx),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst valid", 64'(rk_valid), 64'd0);
        key       = KEY0;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        chk("reload rk",    64'(rk),       64'(kexp[0]));
        chk("reload idx",   64'(rk_idx),   64'd0);
        chk("reload valid", 64'(rk_valid), 64'd1);
        @(negedge clk);
        chk("reload rk1",   64'(rk),       64'(kexp[1]));
        repeat (14) @(negedge clk);
        chk("reload last",  64'(rk_last),  64'd1);
        chk("reload rk15",  64'(rk),       64'(kexp[15]));
        @(negedge clk);
        chk("reload done",  64'(key_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
